wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Shares the two writeback/wakeup ports (writeback0, writeback1) among NUM_REQ functional-unit completion sources, such as ALU, MUL/DIV, LSU and branch units. Each source gets a one-entry holding register. A round-robin arbiter grants up to two holding entries per cycle. The winners are driven through registered writeback outputs, which feed the issue queues' wakeup inputs and the ROB. Entries younger than a redirect flush are discarded before they can win.

## Interface
Parameters:
- NUM_REQ, 4, number of completion sources (2..8)
- PREG_W, 6, physical register index width
- ROB_W, 4, ROB index width (excluding wrap flag)
- DATA_W, 64, result data width

Ports:
- clock  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-source completion valid
- req_ready  out  NUM_REQ  per-source accept
- req_need_to_wb  in  NUM_REQ  result writes a preg
- req_prd  in  NUM_REQ*PREG_W  packed, source i at [i*PREG_W +: PREG_W]
- req_data  in  NUM_REQ*DATA_W  packed result data
- req_robidx_flag  in  NUM_REQ  ROB wrap flag
- req_robidx  in  NUM_REQ*ROB_W  packed ROB index
- writeback0_valid / writeback1_valid  out  1  port valid
- writeback0_need_to_wb / writeback1_need_to_wb  out  1  preg write/wakeup enable
- writeback0_prd / writeback1_prd  out  PREG_W  destination preg
- writeback0_data / writeback1_data  out  DATA_W  result
- writeback0_robidx_flag / writeback1_robidx_flag  out  1
- writeback0_robidx / writeback1_robidx  out  ROB_W
- flush_valid  in  1  redirect flush
- flush_robidx_flag  in  1
- flush_robidx  in  ROB_W

## Operation
- State held by the block:
  - hold_valid[i] and a hold payload (need_to_wb, prd, data, robidx_flag, robidx) per source.
  - rr_ptr, log2(NUM_REQ) bits.
  - Registered writeback outputs.
- Younger test: entry e is younger than the flush point when flush_robidx_flag ^ e.flag ^ (flush_robidx < e.robidx) is 1.
- Kill mask: kill[i] = flush_valid & hold_valid[i] & younger(hold[i]).
- Arbitration candidates: cand = hold_valid & ~kill.
- Grant ordering: scan indices rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - The first candidate found is g0 and goes to port 0.
  - The second candidate found is g1 and goes to port 1.
  - At most 2 grants per cycle.
- rr_ptr update:
  - If g1 exists: rr_ptr_next = g1+1 mod NUM_REQ.
  - Else if g0 exists: rr_ptr_next = g0+1 mod NUM_REQ.
  - Else rr_ptr is unchanged.
- Accept rule: req_ready[i] = ~hold_valid[i] | grant[i] | kill[i]. A slot freed this cycle is refilled at the same edge.
- Capture: on req_valid[i] & req_ready[i], the hold loads the request payload.
  - Exception: if flush_valid is 1 and the incoming request is younger than the flush point, it is dropped and the hold ends empty.
- Hold clear: if a hold is granted or killed and not refilled, hold_valid[i] becomes 0.
- Output registers:
  - writebackN_valid <= 1 and the payload registers load from gN if gN exists.
  - Otherwise writebackN_valid <= 0 and the payload registers hold their previous value.
- Sources with need_to_wb=0 still consume a port. The port is driven with need_to_wb=0 so that only ROB completion happens and no wakeup occurs.
- Flush does not retract writeback outputs already registered. The ROB ignores writebacks from flushed entries.

## Timing
- Reset values (asynchronous):
  - hold_valid = 0 and rr_ptr = 0.
  - Every writeback output = 0, including valid, need_to_wb, prd, data, robidx_flag and robidx.
  - req_ready = all ones.
- Latency: a request accepted in cycle c is in its hold in c+1. If granted in c+1, writeback valid appears in c+2. Minimum latency is 2 cycles.
- Throughput: one result per source per cycle when uncontended; two results total per cycle.
- req_ready is combinational from hold_valid, grant and flush. It does not depend on req_valid.
- Contention: with k ≥ 3 held candidates, each waits at most ceil((k-2)/2)+1 grant cycles (round-robin fairness).
- Simultaneous flush and capture in the same cycle: the younger-than-flush comparison is applied to both held and incoming entries.
- Reset mid-operation: all holds are dropped immediately and outputs go to 0. No partial writeback follows reset release.

## Test plan
- Single request: reset, then source 2 valid with prd=5, data=0xAB, robidx=3 in cycle 1 → writeback0_valid=1, prd=5, data=0xAB in cycle 3. writeback1_valid=0. rr_ptr=3.
- Dual grant: sources 0 and 1 valid in the same cycle with rr_ptr=0 → 2 cycles later port0 carries source 0 and port1 carries source 1. Both sources see req_ready=1 again one cycle after capture.
- Round robin: all 4 sources valid continuously → grant pairs are (0,1), (2,3), (0,1), … Every source is granted every 2 cycles and no source is starved.
- Flush kill: holds exist for robidx 2 (flag 0) and robidx 6 (flag 0); flush_robidx=4, flag 0 → only robidx 2 reaches writeback. Hold 6 is cleared and its req_ready=1 in the flush cycle.
- Flush on wrap: hold has flag=1, robidx=1; flush flag=0, robidx=14 → the entry is younger and is killed. A hold with flag=0, robidx=13 survives.
- No-wakeup completion: source 3 sends need_to_wb=0 → writeback valid=1 with need_to_wb=0. Reset asserted mid-stream → all outputs go to 0 within the same cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares two registered writeback/wakeup ports among NUM_REQ completion sources.
// Latency: 2 cycles minimum (capture into a one-entry hold, then grant into the output register).
// Backpressure: req_ready[i] is high when hold i is empty, granted or killed this cycle; no credits.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   req_*                    per-source completion payload, packed source i at [i*W +: W]
//   req_ready                per-source accept (combinational from hold state, grant and flush)
//   writeback0_*/1_*         registered winner payloads driving the issue-queue wakeup and the ROB
//   flush_*                  redirect flush point; held and incoming entries younger than it are dropped
module wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_need_to_wb,
  input  logic [NUM_REQ*PREG_W-1:0] req_prd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_robidx_flag,
  input  logic [NUM_REQ*ROB_W-1:0]  req_robidx,
  output logic                      writeback0_valid,
  output logic                      writeback0_need_to_wb,
  output logic [PREG_W-1:0]         writeback0_prd,
  output logic [DATA_W-1:0]         writeback0_data,
  output logic                      writeback0_robidx_flag,
  output logic [ROB_W-1:0]          writeback0_robidx,
  output logic                      writeback1_valid,
  output logic                      writeback1_need_to_wb,
  output logic [PREG_W-1:0]         writeback1_prd,
  output logic [DATA_W-1:0]         writeback1_data,
  output logic                      writeback1_robidx_flag,
  output logic [ROB_W-1:0]          writeback1_robidx,
  input  logic                      flush_valid,
  input  logic                      flush_robidx_flag,
  input  logic [ROB_W-1:0]          flush_robidx
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic              need_to_wb;
    logic [PREG_W-1:0] prd;
    logic [DATA_W-1:0] data;
    logic              robidx_flag;
    logic [ROB_W-1:0]  robidx;
  } ent_t;

  // Differing wrap flags invert the plain index comparison.
  function automatic logic is_younger(input logic f_flag, input logic [ROB_W-1:0] f_idx,
                                      input logic e_flag, input logic [ROB_W-1:0] e_idx);
    return f_flag ^ e_flag ^ (f_idx < e_idx);
  endfunction

  // (p + k) mod NUM_REQ, valid for NUM_REQ that is not a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  ent_t               req_ent [NUM_REQ];
  ent_t               hold_q  [NUM_REQ];
  logic [NUM_REQ-1:0] hold_valid;
  logic [NUM_REQ-1:0] kill;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] in_young;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PTR_W-1:0]   g0_idx;
  logic [PTR_W-1:0]   g1_idx;
  logic               g0_vld;
  logic               g1_vld;
  ent_t               wb0_q;
  ent_t               wb1_q;
  logic               wb0_vld_q;
  logic               wb1_vld_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ent[i].need_to_wb  = req_need_to_wb[i];
      req_ent[i].prd         = req_prd[i*PREG_W +: PREG_W];
      req_ent[i].data        = req_data[i*DATA_W +: DATA_W];
      req_ent[i].robidx_flag = req_robidx_flag[i];
      req_ent[i].robidx      = req_robidx[i*ROB_W +: ROB_W];
    end
  end

  always_comb begin
    kill     = '0;
    in_young = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      kill[i] = flush_valid & hold_valid[i] &
                is_younger(flush_robidx_flag, flush_robidx, hold_q[i].robidx_flag, hold_q[i].robidx);
      in_young[i] = flush_valid &
                    is_younger(flush_robidx_flag, flush_robidx, req_ent[i].robidx_flag, req_ent[i].robidx);
    end
    cand = hold_valid & ~kill;
  end

  // Round-robin scan starting at rr_ptr; first two candidates win.
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand[wrap_add(rr_ptr, k)]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = wrap_add(rr_ptr, k);
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = wrap_add(rr_ptr, k);
        end
      end
    end

    grant = '0;
    if (g0_vld) grant[g0_idx] = 1'b1;
    if (g1_vld) grant[g1_idx] = 1'b1;

    if (g1_vld)      rr_ptr_next = wrap_add(g1_idx, 1);
    else if (g0_vld) rr_ptr_next = wrap_add(g0_idx, 1);
    else             rr_ptr_next = rr_ptr;
  end

  // A slot leaving this cycle (granted or killed) can be refilled at the same edge.
  assign req_ready = ~hold_valid | grant | kill;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          // An incoming entry already younger than the flush point never occupies the hold.
          hold_valid[i] <= ~in_young[i];
          hold_q[i]     <= req_ent[i];
        end else if (grant[i] || kill[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Payload registers keep their last value when the port is idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb0_vld_q <= 1'b0;
      wb1_vld_q <= 1'b0;
      wb0_q     <= '0;
      wb1_q     <= '0;
    end else begin
      wb0_vld_q <= g0_vld;
      wb1_vld_q <= g1_vld;
      if (g0_vld) wb0_q <= hold_q[g0_idx];
      if (g1_vld) wb1_q <= hold_q[g1_idx];
    end
  end

  assign writeback0_valid       = wb0_vld_q;
  assign writeback0_need_to_wb  = wb0_q.need_to_wb;
  assign writeback0_prd         = wb0_q.prd;
  assign writeback0_data        = wb0_q.data;
  assign writeback0_robidx_flag = wb0_q.robidx_flag;
  assign writeback0_robidx      = wb0_q.robidx;

  assign writeback1_valid       = wb1_vld_q;
  assign writeback1_need_to_wb  = wb1_q.need_to_wb;
  assign writeback1_prd         = wb1_q.prd;
  assign writeback1_data        = wb1_q.data;
  assign writeback1_robidx_flag = wb1_q.robidx_flag;
  assign writeback1_robidx      = wb1_q.robidx;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven bench for wb_arbiter with hand-computed expectations.
// Latency: rows drive at the falling edge, check req_ready before and writeback after the rising edge.
// Backpressure: expected req_ready per row is part of each table record.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int PW = 6;
  localparam int RW = 4;
  localparam int DW = 64;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_need_to_wb;
  logic [N*PW-1:0] req_prd;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_robidx_flag;
  logic [N*RW-1:0] req_robidx;
  logic            writeback0_valid, writeback0_need_to_wb, writeback0_robidx_flag;
  logic [PW-1:0]   writeback0_prd;
  logic [DW-1:0]   writeback0_data;
  logic [RW-1:0]   writeback0_robidx;
  logic            writeback1_valid, writeback1_need_to_wb, writeback1_robidx_flag;
  logic [PW-1:0]   writeback1_prd;
  logic [DW-1:0]   writeback1_data;
  logic [RW-1:0]   writeback1_robidx;
  logic            flush_valid;
  logic            flush_robidx_flag;
  logic [RW-1:0]   flush_robidx;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  wb_arbiter #(.NUM_REQ(N), .PREG_W(PW), .ROB_W(RW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_need_to_wb(req_need_to_wb),
    .req_prd(req_prd), .req_data(req_data), .req_robidx_flag(req_robidx_flag), .req_robidx(req_robidx),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd), .writeback0_data(writeback0_data),
    .writeback0_robidx_flag(writeback0_robidx_flag), .writeback0_robidx(writeback0_robidx),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd), .writeback1_data(writeback1_data),
    .writeback1_robidx_flag(writeback1_robidx_flag), .writeback1_robidx(writeback1_robidx),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx)
  );

  // Bench payload encoding: prd and data identify (source, robidx).
  function automatic logic [PW-1:0] prd_of(input int s, input logic [RW-1:0] r);
    logic [1:0] s2;
    s2 = 2'(s);
    return {s2, r};
  endfunction

  function automatic logic [DW-1:0] data_of(input int s, input logic [RW-1:0] r);
    return 64'hAB00_0000_0000_0000 | (64'(s) << 8) | 64'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_need_to_wb = '0; req_prd = '0; req_data = '0;
    req_robidx_flag = '0; req_robidx = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
  endtask

  task automatic set_src(input int s, input logic need, input logic flag, input logic [RW-1:0] r,
                         input logic [PW-1:0] prd, input logic [DW-1:0] data);
    req_valid[s]           = 1'b1;
    req_need_to_wb[s]      = need;
    req_robidx_flag[s]     = flag;
    req_robidx[s*RW +: RW] = r;
    req_prd[s*PW +: PW]    = prd;
    req_data[s*DW +: DW]   = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] robs;
    logic [3:0]  flag;
    logic [3:0]  need;
    logic        fv;
    logic [3:0]  fr;
    logic [3:0]  rdy;
    logic        e0v;
    int          e0s;
    logic [3:0]  e0r;
    logic        e0n;
    logic        e0f;
    logic        e1v;
    int          e1s;
    logic [3:0]  e1r;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [15:0] robs, input logic [3:0] flag,
                              input logic [3:0] need, input logic fv, input logic [3:0] fr,
                              input logic [3:0] rdy, input logic e0v, input int e0s,
                              input logic [3:0] e0r, input logic e0n, input logic e0f,
                              input logic e1v, input int e1s, input logic [3:0] e1r);
    vec_t v;
    v.vld = vld; v.robs = robs; v.flag = flag; v.need = need; v.fv = fv; v.fr = fr; v.rdy = rdy;
    v.e0v = e0v; v.e0s = e0s; v.e0r = e0r; v.e0n = e0n; v.e0f = e0f;
    v.e1v = e1v; v.e1s = e1s; v.e1r = e1r;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    // dual grant, round robin with full contention, flush kill, flush on wrap,
    // flush together with capture, no-wakeup completion
    tbl[0]  = mk(4'b0011, 16'h0021, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[1]  = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    1, 0, 4'd1,  1, 0, 1, 1, 4'd2);
    tbl[2]  = mk(4'b1111, 16'h6543, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[3]  = mk(4'b1111, 16'hA987, 4'b0000, 4'hF, 0, 4'd0,  4'b1100, 1, 2, 4'd5,  1, 0, 1, 3, 4'd6);
    tbl[4]  = mk(4'b1111, 16'hCB87, 4'b0000, 4'hF, 0, 4'd0,  4'b0011, 1, 0, 4'd3,  1, 0, 1, 1, 4'd4);
    tbl[5]  = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'b1100, 1, 2, 4'd9,  1, 0, 1, 3, 4'd10);
    tbl[6]  = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    1, 0, 4'd7,  1, 0, 1, 1, 4'd8);
    tbl[7]  = mk(4'b0101, 16'h0602, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[8]  = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 1, 4'd4,  4'hF,    1, 0, 4'd2,  1, 0, 0, 0, 4'd0);
    tbl[9]  = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[10] = mk(4'b0011, 16'h00D1, 4'b0001, 4'hF, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[11] = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 1, 4'd14, 4'hF,    1, 1, 4'd13, 1, 0, 0, 0, 4'd0);
    tbl[12] = mk(4'b0011, 16'h0035, 4'b0000, 4'hF, 1, 4'd4,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[13] = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    1, 1, 4'd3,  1, 0, 0, 0, 4'd0);
    tbl[14] = mk(4'b1000, 16'h7000, 4'b0000, 4'h7, 0, 4'd0,  4'hF,    0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    tbl[15] = mk(4'b0000, 16'h0000, 4'b0000, 4'hF, 0, 4'd0,  4'hF,    1, 3, 4'd7,  0, 0, 0, 0, 4'd0);

    // reset state
    reset_n = 1'b0;
    clear_inputs();
    #2;
    chk("reset_wb0_valid", 64'(writeback0_valid), 64'd0);
    chk("reset_wb1_valid", 64'(writeback1_valid), 64'd0);
    chk("reset_wb0_data",  64'(writeback0_data),  64'd0);
    chk("reset_wb1_prd",   64'(writeback1_prd),   64'd0);
    chk("reset_ready",     64'(req_ready),        64'hF);
    do_reset();

    for (int r = 0; r < 16; r++) begin
      @(negedge clock);
      clear_inputs();
      for (int s = 0; s < N; s++) begin
        logic [3:0] rb;
        rb = tbl[r].robs[s*4 +: 4];
        if (tbl[r].vld[s]) set_src(s, tbl[r].need[s], tbl[r].flag[s], rb, prd_of(s, rb), data_of(s, rb));
      end
      flush_valid  = tbl[r].fv;
      flush_robidx = tbl[r].fr;
      #1;
      chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      @(posedge clock);
      #1;
      chk($sformatf("row%0d_wb0_valid", r), 64'(writeback0_valid), 64'(tbl[r].e0v));
      chk($sformatf("row%0d_wb1_valid", r), 64'(writeback1_valid), 64'(tbl[r].e1v));
      if (tbl[r].e0v) begin
        chk($sformatf("row%0d_wb0_prd", r),  64'(writeback0_prd),  64'(prd_of(tbl[r].e0s, tbl[r].e0r)));
        chk($sformatf("row%0d_wb0_data", r), 64'(writeback0_data), data_of(tbl[r].e0s, tbl[r].e0r));
        chk($sformatf("row%0d_wb0_rob", r),  64'(writeback0_robidx), 64'(tbl[r].e0r));
        chk($sformatf("row%0d_wb0_need", r), 64'(writeback0_need_to_wb), 64'(tbl[r].e0n));
        chk($sformatf("row%0d_wb0_flag", r), 64'(writeback0_robidx_flag), 64'(tbl[r].e0f));
      end
      if (tbl[r].e1v) begin
        chk($sformatf("row%0d_wb1_prd", r),  64'(writeback1_prd),  64'(prd_of(tbl[r].e1s, tbl[r].e1r)));
        chk($sformatf("row%0d_wb1_data", r), 64'(writeback1_data), data_of(tbl[r].e1s, tbl[r].e1r));
        chk($sformatf("row%0d_wb1_rob", r),  64'(writeback1_robidx), 64'(tbl[r].e1r));
      end
    end

    // single request with two-cycle latency, then rr_ptr=3 observed through grant order
    do_reset();
    @(negedge clock);
    clear_inputs();
    set_src(2, 1'b1, 1'b0, 4'd3, 6'd5, 64'hAB);
    @(posedge clock); #1;
    chk("single_early_valid", 64'(writeback0_valid), 64'd0);
    @(negedge clock);
    clear_inputs();
    @(posedge clock); #1;
    chk("single_wb0_valid", 64'(writeback0_valid), 64'd1);
    chk("single_wb0_prd",   64'(writeback0_prd),   64'd5);
    chk("single_wb0_data",  64'(writeback0_data),  64'hAB);
    chk("single_wb0_rob",   64'(writeback0_robidx), 64'd3);
    chk("single_wb1_valid", 64'(writeback1_valid), 64'd0);
    @(negedge clock);
    set_src(0, 1'b1, 1'b0, 4'd1, prd_of(0, 4'd1), data_of(0, 4'd1));
    set_src(3, 1'b1, 1'b0, 4'd2, prd_of(3, 4'd2), data_of(3, 4'd2));
    @(negedge clock);
    clear_inputs();
    @(posedge clock); #1;
    chk("rr3_wb0_prd", 64'(writeback0_prd), 64'(prd_of(3, 4'd2)));
    chk("rr3_wb1_prd", 64'(writeback1_prd), 64'(prd_of(0, 4'd1)));
    @(posedge clock); #1;
    chk("idle_wb0_valid", 64'(writeback0_valid), 64'd0);
    chk("idle_wb0_prd_held", 64'(writeback0_prd), 64'(prd_of(3, 4'd2)));

    // reset asserted mid-stream
    @(negedge clock);
    for (int s = 0; s < N; s++) set_src(s, 1'b1, 1'b0, 4'(s + 4), prd_of(s, 4'(s + 4)), data_of(s, 4'(s + 4)));
    repeat (3) @(posedge clock);
    #1;
    chk("prereset_wb0_valid", 64'(writeback0_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_wb0_valid", 64'(writeback0_valid), 64'd0);
    chk("midreset_wb1_valid", 64'(writeback1_valid), 64'd0);
    chk("midreset_wb0_data",  64'(writeback0_data),  64'd0);
    chk("midreset_wb1_rob",   64'(writeback1_robidx), 64'd0);
    chk("midreset_ready",     64'(req_ready),        64'hF);
    @(negedge clock);
    clear_inputs();
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      chk($sformatf("postreset%0d_wb0_valid", c), 64'(writeback0_valid), 64'd0);
      chk($sformatf("postreset%0d_wb1_valid", c), 64'(writeback1_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
